tuner_seq_ctrl: RTL and testbench
=================================

Name: tuner_seq_ctrl

Overview:
Frame sequencer and shared-memory arbiter for the tuner datapath. It runs one analysis frame as load_mem fill, then in-place fft, then find_freq peak search, and can repeat frames continuously. The single-port 2048x10 sample memory is granted to exactly one phase engine at a time, with a dead cycle between owners. Each phase is bounded by a watchdog, and the peak-bin result is latched per frame.

Parameters:
ADDR_W, 11, memory address width (2048 words)
DATA_W, 10, memory data width
TIMEOUT_CYCLES, 65535, max cycles any single phase may take before abort
CNT_W, 16, width of watchdog and frame counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse; begins a frame when idle
continuous  in  1  level; re-run frames back-to-back while high
abort  in  1  pulse; stop current frame, return to IDLE
load_en  out  1  level enable to load engine (do_load)
load_done  in  1  load engine finished
load_addr  in  ADDR_W  load engine address
load_we  in  1  load engine write enable
load_wdata  in  DATA_W  load engine write data
fft_en  out  1  level enable to fft engine
fft_done  in  1  fft finished
fft_addr  in  ADDR_W  fft address
fft_we  in  1  fft write enable
fft_wdata  in  DATA_W  fft write data
ff_en  out  1  level enable to find_freq
ff_done  in  1  find_freq finished
ff_addr  in  ADDR_W  find_freq read address
ff_bin  in  ADDR_W  find_freq peak index, valid with ff_done
mem_addr  out  ADDR_W  to shared memory
mem_we  out  1  to shared memory
mem_wdata  out  DATA_W  to shared memory
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse per completed frame
freq_bin  out  ADDR_W  last latched peak bin
frame_count  out  CNT_W  completed frames, wraps at 2^CNT_W
timeout_err  out  1  sticky watchdog error
phase  out  3  current state encoding (debug)

Behaviour:
- States (phase encoding): IDLE=0, LOAD=1, GAP1=2, FFT=3, GAP2=4, FREQ=5, DONE=6.
- Reset value of every output is 0: enables low, mem_* low, busy 0, freq_bin 0, frame_count 0, timeout_err 0, phase 0.
- IDLE: on start=1 -> LOAD; start also clears timeout_err. A start seen in any other state is ignored.
- LOAD: load_en=1. On load_done -> GAP1.
- GAP1: all enables low; mem_addr=0, mem_we=0. Next cycle -> FFT.
- FFT: fft_en=1. On fft_done -> GAP2.
- GAP2: all enables low, as GAP1. Next cycle -> FREQ.
- FREQ: ff_en=1. On ff_done, freq_bin<=ff_bin -> DONE.
- DONE: frame_done=1 for this one cycle; frame_count+1. Then -> LOAD if continuous=1, else -> IDLE.
- Enables are registered and decoded from the state register, so enable rises one cycle after state entry and drops in the cycle after the done is sampled.
- Memory mux is combinational from the registered state, zero latency:
  - LOAD -> load_*.
  - FFT -> fft_*.
  - FREQ -> ff_addr with mem_we forced 0 and mem_wdata=0.
  - All other states: mem_addr=0, mem_we=0, mem_wdata=0.
- A done from a non-owning engine is ignored; it never advances the state or latches a result.
- Watchdog:
  - The counter clears on every state entry and increments in LOAD/FFT/FREQ.
  - When it reaches TIMEOUT_CYCLES without the owner's done: timeout_err<=1 -> IDLE, enables dropped, no frame_done, freq_bin unchanged.
  - If done and timeout occur in the same cycle, done wins.
- abort has priority over all transitions. From any state -> IDLE next cycle, enables low, frame_count and freq_bin unchanged. Abort in DONE still counts that frame, because the pulse was already issued.
- start and abort in the same cycle in IDLE: abort wins and the block stays IDLE.
- rst_n=0 mid-frame: every output returns to its reset value on the next edge, regardless of state.
- continuous is sampled only in DONE; dropping it mid-frame finishes the current frame.

Test Plan:
- Reset, pulse start; load_done at +20, fft_done at +50, ff_done with ff_bin=0x123 at +30 -> states 1,2,3,4,5,6,0; freq_bin=0x123; one frame_done; frame_count=1.
- Mux check, LOAD with load_addr=0x7FF, we=1, wdata=0x3FF -> mem matches; in FREQ with ff_addr=0x010 and fft_we=1 -> mem_addr=0x010, mem_we=0; GAP states -> mem_addr=0, mem_we=0.
- TIMEOUT_CYCLES=100, no fft_done -> IDLE after 100 FFT cycles; timeout_err=1, frame_done never pulses; next start clears timeout_err.
- continuous=1 over 3 frames -> DONE goes straight to LOAD each time, with no IDLE between frames; frame_count=3; clear continuous -> IDLE after the 4th frame.
- Stray fft_done and ff_done pulsed during LOAD -> state stays LOAD, freq_bin unchanged; abort during FFT -> IDLE next cycle, fft_en=0.
- ff_done and watchdog expiry in the same cycle -> DONE, freq_bin latched, timeout_err=0; rst_n low during FFT -> all outputs 0 on next edge.

Source files
------------

// File: rtl/tuner_seq_ctrl.sv
// Frame sequencer for the tuner: load -> fft -> find_freq with a dead cycle between
// memory owners, a per-phase watchdog and a per-frame peak-bin latch.
module tuner_seq_ctrl #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              load_en,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_we,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              fft_en,
  input  logic              fft_done,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic              fft_we,
  input  logic [DATA_W-1:0] fft_wdata,
  output logic              ff_en,
  input  logic              ff_done,
  input  logic [ADDR_W-1:0] ff_addr,
  input  logic [ADDR_W-1:0] ff_bin,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] freq_bin,
  output logic [CNT_W-1:0]  frame_count,
  output logic              timeout_err,
  output logic [2:0]        phase
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    GAP1 = 3'd2,
    FFT  = 3'd3,
    GAP2 = 3'd4,
    FREQ = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] wd;
  logic             active;
  logic             own_done;
  logic             expired;

  assign phase = state;

  always_comb begin
    active   = (state == LOAD) || (state == FFT) || (state == FREQ);
    own_done = ((state == LOAD) && load_done) ||
               ((state == FFT)  && fft_done)  ||
               ((state == FREQ) && ff_done);
    // wd counts completed cycles in the phase, so this edge closes cycle number TIMEOUT_CYCLES
    expired  = active && (wd == CNT_W'(TIMEOUT_CYCLES - 1));
    next     = state;
    if (abort) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next = LOAD;
        LOAD:    if (load_done) next = GAP1; else if (expired) next = IDLE;
        GAP1:    next = FFT;
        FFT:     if (fft_done) next = GAP2; else if (expired) next = IDLE;
        GAP2:    next = FREQ;
        FREQ:    if (ff_done) next = DONE; else if (expired) next = IDLE;
        DONE:    next = continuous ? LOAD : IDLE;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wd          <= '0;
      load_en     <= 1'b0;
      fft_en      <= 1'b0;
      ff_en       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      freq_bin    <= '0;
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next;
      if (next != state || !active) wd <= '0;
      else                          wd <= wd + 1'b1;
      // enable follows the owner one cycle late and drops on the leaving edge
      load_en    <= (state == LOAD) && (next == LOAD);
      fft_en     <= (state == FFT)  && (next == FFT);
      ff_en      <= (state == FREQ) && (next == FREQ);
      busy       <= (next != IDLE);
      frame_done <= (next == DONE);
      if (next == DONE) frame_count <= frame_count + 1'b1;
      if (!abort && (state == FREQ) && ff_done) freq_bin <= ff_bin;
      if (!abort && (state == IDLE) && start)
        timeout_err <= 1'b0;
      else if (!abort && expired && !own_done)
        timeout_err <= 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      LOAD: begin
        mem_addr  = load_addr;
        mem_we    = load_we;
        mem_wdata = load_wdata;
      end
      FFT: begin
        mem_addr  = fft_addr;
        mem_we    = fft_we;
        mem_wdata = fft_wdata;
      end
      FREQ:    mem_addr = ff_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Bench for tuner_seq_ctrl: directed frame scenarios plus random traffic against a cycle model.
module tb_tuner_seq_ctrl;
  localparam int AW = 11;
  localparam int DW = 10;
  localparam int CW = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n, start, continuous, abort;
  logic          load_en, load_done, load_we, fft_en, fft_done, fft_we, ff_en, ff_done;
  logic [AW-1:0] load_addr, fft_addr, ff_addr, ff_bin, mem_addr, freq_bin;
  logic [DW-1:0] load_wdata, fft_wdata, mem_wdata;
  logic          mem_we, busy, frame_done, timeout_err;
  logic [CW-1:0] frame_count;
  logic [2:0]    phase;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: phase number, cycles spent in it, and latched outputs
  int            m_state, m_wd;
  logic          m_le, m_fe, m_ffe, m_fd, m_terr;
  logic [AW-1:0] m_freq;
  logic [CW-1:0] m_cnt;
  logic [AW-1:0] last_bin;

  tuner_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .load_en(load_en), .load_done(load_done), .load_addr(load_addr), .load_we(load_we),
    .load_wdata(load_wdata), .fft_en(fft_en), .fft_done(fft_done), .fft_addr(fft_addr),
    .fft_we(fft_we), .fft_wdata(fft_wdata), .ff_en(ff_en), .ff_done(ff_done),
    .ff_addr(ff_addr), .ff_bin(ff_bin), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done), .freq_bin(freq_bin),
    .frame_count(frame_count), .timeout_err(timeout_err), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    int  prev, nxt;
    bit  is_work, own, exp_hit;
    if (!rst_n) begin
      m_state = 0; m_wd = 0; m_le = 0; m_fe = 0; m_ffe = 0; m_fd = 0;
      m_terr = 0; m_freq = '0; m_cnt = '0;
      return;
    end
    prev    = m_state;
    is_work = (prev == 1) || (prev == 3) || (prev == 5);
    own     = (prev == 1 && load_done) || (prev == 3 && fft_done) || (prev == 5 && ff_done);
    exp_hit = is_work && (m_wd + 1 >= TO);
    if (abort)                nxt = 0;
    else if (prev == 0)       nxt = start ? 1 : 0;
    else if (prev == 6)       nxt = continuous ? 1 : 0;
    else if (!is_work)        nxt = prev + 1;
    else if (own)             nxt = prev + 1;
    else if (exp_hit)         nxt = 0;
    else                      nxt = prev;
    if (!abort && prev == 0 && start) m_terr = 0;
    else if (!abort && is_work && !own && exp_hit) m_terr = 1;
    if (!abort && prev == 5 && ff_done) m_freq = ff_bin;
    if (nxt == 6) m_cnt = m_cnt + 1'b1;
    m_le  = (prev == 1 && nxt == 1);
    m_fe  = (prev == 3 && nxt == 3);
    m_ffe = (prev == 5 && nxt == 5);
    m_fd  = (nxt == 6);
    m_wd  = (nxt == prev && is_work) ? m_wd + 1 : 0;
    m_state = nxt;
  endtask

  task automatic check_all();
    logic [AW+DW:0] exp_mem;
    chk("outputs",
        {phase, busy, load_en, fft_en, ff_en, frame_done, timeout_err, freq_bin, frame_count},
        {3'(m_state), (m_state != 0), m_le, m_fe, m_ffe, m_fd, m_terr, m_freq, m_cnt});
    case (m_state)
      1:       exp_mem = {load_addr, load_we, load_wdata};
      3:       exp_mem = {fft_addr, fft_we, fft_wdata};
      5:       exp_mem = {ff_addr, 1'b0, {DW{1'b0}}};
      default: exp_mem = '0;
    endcase
    chk("mem_mux", {mem_addr, mem_we, mem_wdata}, exp_mem);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_all();
  endtask

  // expects the DUT in LOAD; leaves it in DONE
  task automatic do_frame(input int dl, input int df, input int dq, input logic [AW-1:0] bin);
    repeat (dl) tick();
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick();
    repeat (df) tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    tick();
    repeat (dq) tick();
    ff_bin = bin; ff_done = 1'b1; tick(); ff_done = 1'b0;
    last_bin = bin;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; continuous = 0; abort = 0;
    load_done = 0; load_we = 0; fft_done = 0; fft_we = 0; ff_done = 0;
    load_addr = '0; fft_addr = '0; ff_addr = '0; ff_bin = '0;
    load_wdata = '0; fft_wdata = '0;
    m_state = 0; m_wd = 0; last_bin = '0;
    tick(); tick();
    chk("reset_outs", {phase, busy, load_en, fft_en, ff_en, frame_done, timeout_err, freq_bin, frame_count}, 0);
    rst_n = 1'b1;

    // basic frame with memory mux observation
    start = 1'b1; tick(); start = 1'b0;
    chk("f1_load", phase, 1);
    load_addr = 11'h7FF; load_we = 1'b1; load_wdata = 10'h3FF;
    repeat (19) tick();
    chk("mux_load", {mem_addr, mem_we, mem_wdata}, {11'h7FF, 1'b1, 10'h3FF});
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("f1_gap1", phase, 2);
    chk("mux_gap1", {mem_addr, mem_we}, 0);
    tick(); chk("f1_fft", phase, 3);
    repeat (49) tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk("f1_gap2", phase, 4);
    tick(); chk("f1_freq", phase, 5);
    ff_addr = 11'h010; fft_we = 1'b1; #1;
    chk("mux_freq", {mem_addr, mem_we}, {11'h010, 1'b0});
    repeat (29) tick();
    ff_bin = 11'h123; ff_done = 1'b1; tick(); ff_done = 1'b0; fft_we = 1'b0; load_we = 1'b0;
    chk("f1_done", {phase, frame_done}, {3'd6, 1'b1});
    tick();
    chk("f1_end", {phase, freq_bin, frame_count}, {3'd0, 11'h123, 16'd1});
    last_bin = 11'h123;

    // watchdog expiry in FFT
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick(); chk("to_fft", phase, 3);
    repeat (TO - 1) tick();
    chk("to_still_fft", phase, 3);
    tick();
    chk("to_idle", {phase, timeout_err, frame_count}, {3'd0, 1'b1, 16'd1});
    start = 1'b1; tick(); start = 1'b0;
    chk("to_clear", {phase, timeout_err}, {3'd1, 1'b0});
    abort = 1'b1; tick(); abort = 1'b0;
    chk("to_abort_idle", phase, 0);

    // continuous frames
    do_reset();
    continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (f == 3) continuous = 1'b0;
      do_frame($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), AW'($urandom));
      chk("cont_done", phase, 6);
      tick();
      chk("cont_next", {phase, frame_count}, {((f < 3) ? 3'd1 : 3'd0), 16'(f + 1)});
    end

    // stray dones during LOAD, then abort in FFT
    start = 1'b1; tick(); start = 1'b0;
    tick();
    fft_done = 1'b1; ff_done = 1'b1; ff_bin = 11'h555; tick(); fft_done = 1'b0; ff_done = 1'b0;
    chk("stray", {phase, freq_bin}, {3'd1, last_bin});
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick(); tick(); tick();
    chk("ab_fft_en", fft_en, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_idle", {phase, fft_en, freq_bin, frame_count}, {3'd0, 1'b0, last_bin, 16'd4});

    // ff_done coincides with watchdog expiry
    start = 1'b1; tick(); start = 1'b0;
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    tick(); chk("race_freq", phase, 5);
    repeat (TO - 1) tick();
    ff_bin = 11'h2AA; ff_done = 1'b1; tick(); ff_done = 1'b0;
    chk("race_done", {phase, freq_bin, timeout_err}, {3'd6, 11'h2AA, 1'b0});
    tick();

    // reset in the middle of FFT
    start = 1'b1; tick(); start = 1'b0;
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0; tick();
    chk("rst_mid", {phase, busy, load_en, fft_en, ff_en, frame_done, timeout_err, freq_bin,
                    frame_count, mem_addr, mem_we, mem_wdata}, 0);
    rst_n = 1'b1;

    // random traffic: busy engines first, then sluggish ones that provoke timeouts
    for (int i = 0; i < 1500; i++) begin
      int dmax;
      dmax = (i < 800) ? 5 : 150;
      rst_n      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      load_done  = ($urandom_range(0, dmax) == 0);
      fft_done   = ($urandom_range(0, dmax) == 0);
      ff_done    = ($urandom_range(0, dmax) == 0);
      load_addr  = AW'($urandom); fft_addr  = AW'($urandom); ff_addr = AW'($urandom);
      ff_bin     = AW'($urandom);
      load_we    = 1'($urandom);  fft_we    = 1'($urandom);
      load_wdata = DW'($urandom); fft_wdata = DW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
